dbg_hex_pager: RTL and testbench

Parametrised debug-display pager that drives a bank of active-low 7-segment digits from an arbitrary number of debug words. Words are grouped into pages that fit the available digits. Pages are selected by a debounced pushbutton or by an optional auto-cycle timer, and the shown values can be frozen by a hold input. It sits between the DUT's debug outputs and the board HEX pins, replacing fixed two-word wiring.

---
 rtl/dbg_hex_pager.sv | 137 +++++++++++++
 tb/tb_dbg_hex_pager.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_hex_pager.sv
// Debug-word pager for a bank of active-low 7-segment digits.
// Words are grouped into pages; a debounced button or a timer steps pages, hold freezes the values.
module dbg_hex_pager #(
    parameter int NUM_WORDS   = 4,
    parameter int WORD_W      = 16,
    parameter int NUM_DIGITS  = 8,
    parameter int DB_CYCLES   = 8333,
    parameter int AUTO_CYCLES = 8333333,
    localparam int DPW        = WORD_W / 4,
    localparam int WPP        = NUM_DIGITS / DPW,
    localparam int NUM_PAGES  = (NUM_WORDS + WPP - 1) / WPP,
    localparam int PG_W       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic                          pgr_clk_i,
    input  logic                          pgr_rstn_i,
    input  logic [NUM_WORDS*WORD_W-1:0]   pgr_words_i,
    input  logic                          pgr_nextn_i,
    input  logic                          pgr_auto_i,
    input  logic                          pgr_hold_i,
    output logic [NUM_DIGITS*7-1:0]       pgr_segs_o,
    output logic [PG_W-1:0]               pgr_page_o,
    output logic                          pgr_press_o
);

    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int AUTO_W = $clog2(AUTO_CYCLES);
    localparam int PG_N   = 2 ** PG_W;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    logic                        sync1_q, sync1_d;
    logic                        sync2_q, sync2_d;
    logic                        db_lvl_q, db_lvl_d;
    logic [DB_W-1:0]             db_cnt_q, db_cnt_d;
    logic                        press_q, press_d;
    logic [AUTO_W-1:0]           auto_cnt_q, auto_cnt_d;
    logic                        auto_tick;
    logic [PG_W-1:0]             page_q, page_d;
    logic [NUM_WORDS*WORD_W-1:0] snap_q, snap_d;
    logic [NUM_DIGITS*7-1:0]     segs_q, segs_d;

    // Every possible page is rendered in parallel; slots past the last word (and unused
    // page codes when NUM_PAGES is not a power of two) are tied to blank.
    logic [PG_N-1:0][NUM_DIGITS*7-1:0] page_segs;

    for (genvar p = 0; p < PG_N; p++) begin : g_page
        for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
            localparam int W = p * WPP + d / DPW;
            if (W < NUM_WORDS) begin : g_live
                assign page_segs[p][d*7 +: 7] = glyph(snap_q[W*WORD_W + (d % DPW)*4 +: 4]);
            end else begin : g_blank
                assign page_segs[p][d*7 +: 7] = 7'h7F;
            end
        end
    end

    always_comb begin
        sync1_d  = pgr_nextn_i;
        sync2_d  = sync1_q;

        db_lvl_d = db_lvl_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                db_lvl_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        // A press restarts the timer, so a coincident tick and press yield one advance.
        auto_tick = pgr_auto_i && (auto_cnt_q == AUTO_W'(AUTO_CYCLES - 1));
        if (!pgr_auto_i || press_q || auto_tick) begin
            auto_cnt_d = '0;
        end else begin
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
        end

        page_d = page_q;
        if (press_q || auto_tick) begin
            page_d = (page_q == PG_W'(NUM_PAGES - 1)) ? '0 : page_q + PG_W'(1);
        end

        snap_d = pgr_hold_i ? snap_q : pgr_words_i;
        segs_d = page_segs[page_q];
    end

    always_ff @(posedge pgr_clk_i or negedge pgr_rstn_i) begin
        if (!pgr_rstn_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_lvl_q   <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            auto_cnt_q <= '0;
            page_q     <= '0;
            snap_q     <= '0;
            segs_q     <= '1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_lvl_q   <= db_lvl_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            auto_cnt_q <= auto_cnt_d;
            page_q     <= page_d;
            snap_q     <= snap_d;
            segs_q     <= segs_d;
        end
    end

    assign pgr_segs_o  = segs_q;
    assign pgr_page_o  = page_q;
    assign pgr_press_o = press_q;

endmodule

// File: tb/tb_dbg_hex_pager.sv
// Bench for dbg_hex_pager: directed scenarios with literal expectations, then random traffic,
// all continuously compared against a behavioural model of the pager.
module tb_dbg_hex_pager;

    localparam int NW   = 3;
    localparam int DB   = 4;
    localparam int AUTO = 20;
    localparam int WPPM = 2;
    localparam int NPG  = 2;

    localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    localparam logic [55:0] LIT_P0   = {7'h12, 7'h02, 7'h78, 7'h00, 7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [55:0] LIT_P1   = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E};
    localparam logic [55:0] LIT_ZERO = {8{7'h40}};
    localparam logic [55:0] LIT_BLNK = {8{7'h7F}};

    logic        clk;
    logic        rstn;
    logic [47:0] words;
    logic        nextn;
    logic        auto_en;
    logic        hold;
    logic [55:0] segs;
    logic [0:0]  page;
    logic        press;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    dbg_hex_pager #(
        .NUM_WORDS(NW), .WORD_W(16), .NUM_DIGITS(8), .DB_CYCLES(DB), .AUTO_CYCLES(AUTO)
    ) dut (
        .pgr_clk_i(clk), .pgr_rstn_i(rstn), .pgr_words_i(words), .pgr_nextn_i(nextn),
        .pgr_auto_i(auto_en), .pgr_hold_i(hold), .pgr_segs_o(segs), .pgr_page_o(page),
        .pgr_press_o(press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sync pipe of raw samples, run-length debounce, modulo paging,
    // and display rendered from word-index arithmetic over the frozen/live snapshot.
    logic [15:0] m_snap [NW];
    logic [6:0]  m_segs [8];
    int          m_page, m_acnt, m_run;
    logic        m_s1, m_s2, m_lvl, m_press;

    function automatic logic [6:0] show(input int pg, input int d);
        int w;
        int nib;
        w = pg * WPPM + d / 4;
        if (w >= NW) return 7'h7F;
        nib = int'((m_snap[w] >> (4 * (d % 4))) & 16'hF);
        return GLY[nib];
    endfunction

    function automatic logic [55:0] model_segs();
        logic [55:0] e;
        for (int d = 0; d < 8; d++) e[d*7 +: 7] = m_segs[d];
        return e;
    endfunction

    function automatic logic tick_due();
        return auto_en && (m_acnt == AUTO - 1);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NW; k++) m_snap[k] <= 16'h0;
            for (int d = 0; d < 8; d++) m_segs[d] <= 7'h7F;
            m_page  <= 0;
            m_acnt  <= 0;
            m_run   <= 0;
            m_s1    <= 1'b1;
            m_s2    <= 1'b1;
            m_lvl   <= 1'b1;
            m_press <= 1'b0;
        end else begin
            for (int d = 0; d < 8; d++) m_segs[d] <= show(m_page, d);
            for (int k = 0; k < NW; k++) if (!hold) m_snap[k] <= words[k*16 +: 16];
            if (m_press || tick_due()) m_page <= (m_page + 1) % NPG;
            m_acnt <= (!auto_en || m_press || tick_due()) ? 0 : m_acnt + 1;
            m_s1 <= nextn;
            m_s2 <= m_s1;
            if (m_s2 == m_lvl) begin
                m_run   <= 0;
                m_press <= 1'b0;
            end else if (m_run + 1 >= DB) begin
                m_run   <= 0;
                m_lvl   <= m_s2;
                m_press <= !m_s2;
            end else begin
                m_run   <= m_run + 1;
                m_press <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("segs_vs_model", 64'(segs), 64'(model_segs()));
            chk("page_vs_model", 64'(page), 64'(m_page));
            chk("press_vs_model", 64'(press), 64'(m_press));
        end
    end

    task automatic press_btn(input int low_n, output int pulses);
        pulses = 0;
        @(negedge clk);
        nextn = 1'b0;
        for (int i = 0; i < low_n; i++) begin
            @(negedge clk);
            if (press === 1'b1) pulses++;
        end
        nextn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (press === 1'b1) pulses++;
        end
    endtask

    task automatic wait_change(input int budget, output int n);
        logic prev;
        prev = page[0];
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (page[0] !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int pulses;
        int n;
        int first_chg;
        int second_chg;
        int btn_left;
        logic prev;

        rstn    = 1'b1;
        words   = {16'hBEEF, 16'h5678, 16'h1234};
        nextn   = 1'b1;
        auto_en = 1'b0;
        hold    = 1'b0;
        #1 rstn = 1'b0;
        #1 chk_en = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_segs_blank", 64'(segs), 64'(LIT_BLNK));
        chk("reset_page", 64'(page), 64'd0);
        chk("reset_press", 64'(press), 64'd0);

        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_snapshot_zero", 64'(segs), 64'(LIT_ZERO));
        @(posedge clk); #1;
        chk("live_page0", 64'(segs), 64'(LIT_P0));

        press_btn(2, pulses);
        chk("glitch_no_pulse", 64'(pulses), 64'd0);
        chk("glitch_page", 64'(page), 64'd0);

        press_btn(10, pulses);
        chk("press_one_pulse", 64'(pulses), 64'd1);
        chk("press_page1", 64'(page), 64'd1);
        chk("page1_segs", 64'(segs), 64'(LIT_P1));

        press_btn(10, pulses);
        chk("press2_one_pulse", 64'(pulses), 64'd1);
        chk("press2_wrap", 64'(page), 64'd0);
        chk("wrap_segs", 64'(segs), 64'(LIT_P0));

        @(negedge clk);
        auto_en = 1'b1;
        wait_change(40, n);
        chk("auto_first_change_seen", 64'(n > 0), 64'd1);
        wait_change(40, n);
        chk("auto_interval", 64'(n), 64'd20);

        auto_en = 1'b0;
        repeat (5) @(negedge clk);
        auto_en = 1'b1;
        wait_change(40, n);
        chk("auto_reenable_interval", 64'(n), 64'd20);

        // Anchor on the change just seen; the press is timed to land on the timer's last count.
        first_chg  = -1;
        second_chg = -1;
        pulses     = 0;
        prev       = page[0];
        for (int i = 1; i <= 45; i++) begin
            if (i == 14) nextn = 1'b0;
            if (i == 24) nextn = 1'b1;
            @(negedge clk);
            if (press === 1'b1) pulses++;
            if (page[0] !== prev) begin
                if (first_chg < 0) first_chg = i;
                else if (second_chg < 0) second_chg = i;
                prev = page[0];
            end
        end
        chk("coincide_one_pulse", 64'(pulses), 64'd1);
        chk("coincide_first_change", 64'(first_chg), 64'd20);
        chk("coincide_timer_restart", 64'(second_chg), 64'd40);

        @(negedge clk);
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        if (page[0] !== 1'b0) press_btn(10, pulses);
        repeat (3) @(negedge clk);
        chk("hold_pre_page0", 64'(segs), 64'(LIT_P0));

        hold = 1'b1;
        words[15:0] = 16'h0000;
        repeat (4) @(negedge clk);
        chk("hold_frozen", 64'(segs), 64'(LIT_P0));
        press_btn(10, pulses);
        chk("hold_browse_p1", 64'(segs), 64'(LIT_P1));
        press_btn(10, pulses);
        chk("hold_browse_p0", 64'(segs), 64'(LIT_P0));

        @(negedge clk);
        hold = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("hold_release_live", 64'(segs[27:0]), 64'({4{7'h40}}));

        press_btn(10, pulses);
        chk("prereset_page1", 64'(page), 64'd1);
        @(negedge clk);
        nextn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_page", 64'(page), 64'd0);
        chk("async_reset_segs", 64'(segs), 64'(LIT_BLNK));
        chk("async_reset_press", 64'(press), 64'd0);
        @(negedge clk);
        nextn = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rereset_snapshot_zero", 64'(segs), 64'(LIT_ZERO));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (press === 1'b1) pulses++;
        end
        chk("rereset_no_press", 64'(pulses), 64'd0);

        btn_left = 5;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                words[31:0]  = $urandom;
                words[47:32] = 16'($urandom);
            end
            if ($urandom_range(0, 49) == 0) hold = ~hold;
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            if (btn_left == 0) begin
                nextn = ~nextn;
                btn_left = $urandom_range(1, 9);
            end else begin
                btn_left--;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
